bcd_count_ctrl: RTL
===================

# bcd_count_ctrl

Stopwatch-style controller for a 4-digit cascaded decade (0–9) counter chain. It owns the run/pause/clear sequencing, generates the count-enable tick from `mclk` with a programmable prescaler, and produces the ripple-carry enables between digits. It also provides a lap-hold display freeze and a sticky overflow flag. It sits between the push-button/command front end and the 7-segment display driver.

## Interface
- `DIV`, default 10: prescaler ratio; one count tick every `DIV` `mclk` cycles while counting. Legal range 2..65535.
- `mclk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_stop`  in  1  single-cycle command pulse: start or resume, or pause.
- `clear`  in  1  single-cycle command pulse: zero the count; accepted only in PAUSE.
- `lap`  in  1  single-cycle command pulse: freeze or unfreeze the display while counting continues.
- `cnt`  out  16  live count, BCD; `[3:0]` is digit0 (LSD), `[15:12]` is digit3.
- `disp`  out  16  display value, BCD: the lap register in LAP, otherwise `cnt`.
- `running`  out  1  high in RUN or LAP.
- `frozen`  out  1  high in LAP.
- `tick`  out  1  high in the cycle before each count increment.
- `ovf`  out  1  sticky; set on wrap from 9999 to 0000.

## Operation
- The FSM has four states: IDLE, RUN, LAP, PAUSE. Reset puts it in IDLE.
- Reset values: `cnt`=0, lap register=0, prescaler=0, `ovf`=0, `running`=0, `frozen`=0, `tick`=0, `disp`=0.
- Transitions are evaluated at the clock edge where the command is sampled high:
  - IDLE: `start_stop` → RUN. `clear` and `lap` are ignored.
  - RUN: `start_stop` → PAUSE. `lap` → LAP, and the lap register loads the current `cnt` (the pre-increment value if a tick occurs on that edge). `clear` is ignored.
  - LAP: `lap` → RUN, and `disp` tracks live again. `start_stop` → PAUSE, and `disp` returns to live `cnt`. `clear` is ignored.
  - PAUSE: `start_stop` → RUN. `clear` → IDLE, which zeroes `cnt` and the prescaler and clears `ovf`. `lap` is ignored.
- Simultaneous commands: priority is `start_stop` > `clear` > `lap`. Only the highest-priority command that is valid in the current state acts; the others are dropped, not queued.
- Commands held high for several cycles act on every sampled edge. Debounce and single-pulse conditioning are upstream.
- Prescaler:
  - Counts 0..DIV-1 in RUN and LAP, wrapping to 0.
  - `tick` = counting state && prescaler == DIV-1.
  - In PAUSE the prescaler holds its value, so a resume completes the partial period.
  - In IDLE the prescaler is 0.
- Digit cascade, on the edge where `tick` is high:
  - digit0 increments.
  - digit n (n = 1..3) increments when every lower digit is 9.
  - Any digit at 9 that increments wraps to 0.
  - No digit ever holds a value greater than 9.
- Overflow: a tick at 9999 gives 0000 and sets `ovf`, and counting continues. `ovf` clears only on `clear` (PAUSE → IDLE) or on `rst`.
- `disp` is a combinational mux of registers: lap register when `frozen`, otherwise `cnt`. `running`, `frozen` and `tick` are decoded from registered state.
- Reset mid-operation: asserting `rst` in any state immediately forces every reset value, with no wait for a clock edge. After `rst` deasserts, the block sits in IDLE until `start_stop`.

## Timing
- `start_stop` sampled at edge k in IDLE or PAUSE: `running`=1 after edge k.
- From IDLE (prescaler 0), `tick` is high in the cycle after edge k+DIV-1, and `cnt` increments at edge k+DIV. Steady state is one increment per DIV cycles.
- A tick and a `start_stop`→PAUSE on the same edge: the increment is applied and the prescaler wraps to 0.
- `lap` capture has one-edge latency, and `disp` is frozen in the cycle after the sampling edge.
- `clear` in PAUSE: `cnt`=0 and `ovf`=0 in the cycle after the sampling edge.

## Test plan
1. Reset, then `start_stop` at edge k, with `DIV`=4 → first `cnt` increment to 0001 at edge k+4; `cnt`=0010 after 40 cycles; `tick` period is exactly 4.
2. Cascade check: run through 0009→0010, 0099→0100 and 0999→1000 on single ticks. No digit ever reads 0xA–0xF.
3. Overflow: reach 9999, then one more tick → `cnt`=0000 and `ovf`=1, with counting continuing. Then pause and `clear` → `cnt`=0, `ovf`=0, state IDLE.
4. Lap: `lap` at `cnt`=0012 → `disp` holds 0012 while `cnt` advances to 0020. A second `lap` → `disp`=`cnt`. `lap` then `start_stop` → PAUSE with `disp`=`cnt`.
5. Pause/resume with prescaler=2 of DIV=4 → after resume, the next increment comes 2 cycles later. `clear` in RUN or LAP and `lap` in PAUSE have no effect.
6. Simultaneous `start_stop`+`clear` in PAUSE → RUN with the count kept. Async `rst` mid-RUN → all outputs 0 within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_count_ctrl
// Purpose  : Stopwatch controller for a 4-digit BCD counter with prescaled
//            tick, lap-hold display freeze and sticky overflow.
// Revision : 1.0  initial release
// ============================================================================
module bcd_count_ctrl #(
    parameter int DIV = 10
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] cnt,
    output logic [15:0] disp,
    output logic        running,
    output logic        frozen,
    output logic        tick,
    output logic        ovf
);

    localparam logic [15:0] c_PRESC_MAX = 16'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_presc;
    logic [15:0] w_presc_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_cnt_inc;
    logic [15:0] r_lap;
    logic [15:0] w_lap_nxt;
    logic        r_ovf;
    logic        w_ovf_nxt;
    logic        w_counting;
    logic        w_tick;
    logic        w_carry;

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == c_PRESC_MAX);

    // Ripple carry through the decades; a digit at 9 (or corrupt >9) wraps to 0.
    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_cnt[4*i +: 4] >= 4'd9) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                end
                w_carry = (r_cnt[4*i +: 4] >= 4'd9);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        w_lap_nxt   = r_lap;
        w_ovf_nxt   = r_ovf;

        if (w_counting) begin
            w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
        end
        if (w_tick) begin
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == 16'h9999) begin
                w_ovf_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_presc_nxt = 16'd0;
                if (start_stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (start_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (lap) begin
                    w_state_nxt = S_LAP;
                    w_lap_nxt   = r_cnt;
                end
            end
            S_LAP: begin
                if (start_stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (lap) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (start_stop) begin
                    w_state_nxt = S_RUN;
                end else if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_presc_nxt = 16'd0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= 16'd0;
            r_cnt   <= 16'd0;
            r_lap   <= 16'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lap   <= w_lap_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign cnt     = r_cnt;
    assign frozen  = (r_state == S_LAP);
    assign running = w_counting;
    assign tick    = w_tick;
    assign ovf     = r_ovf;
    assign disp    = frozen ? r_lap : r_cnt;

endmodule
`default_nettype wire
